data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the processor data-memory port (mem_read/mem_write/address/mem_write_data/mem_read_data).
//  Stores are posted into a small FIFO write buffer that drains to a word array at a fixed slower rate.
//  Loads see the youngest matching buffered store first (store-to-load forwarding), then the array.
//  Instantiated beside the processor in the top level, in place of a purely combinational RAM.
// PARAMETERS
//  ADDR_W          4   word address width; array holds 2**ADDR_W words
//  DATA_W          32  data word width
//  WBUF_DEPTH      4   write-buffer entries (>=2)
//  DRAIN_INTERVAL  2   cycles per drained entry while buffer non-empty (>=1)
// PORTS
//  clock           input   1       rising-edge clock
//  rst             input   1       asynchronous, active-low reset
//  mem_read        input   1       load request, sampled the same cycle
//  mem_write       input   1       store request, sampled at the rising edge
//  address         input   ADDR_W  word address for the load or store
//  mem_write_data  input   DATA_W  store data
//  mem_read_data   output  DATA_W  load data, combinational
//  wbuf_full       output  1       occupancy == WBUF_DEPTH
//  wbuf_empty      output  1       occupancy == 0
//  wr_overflow     output  1       sticky: a store was dropped
// BEHAVIOUR
//  Reset (rst=0, async): array words=0, buffer occupancy=0, head/tail pointers=0, drain counter=0, wr_overflow=0.
//   Outputs during reset: mem_read_data=0, wbuf_empty=1, wbuf_full=0.
//  Push: store at edge if mem_write=1 and (occupancy<WBUF_DEPTH or pop this edge).
//   Pushed entry is {address, mem_write_data} at tail; tail wraps modulo WBUF_DEPTH.
//  Drop: mem_write=1, buffer full, no pop this edge -> store discarded, wr_overflow set until reset.
//  Drain counter: held at 0 while empty. Otherwise increments each edge.
//   At value DRAIN_INTERVAL-1: pops head entry into array[addr], head wraps, counter returns to 0.
//  Simultaneous push+pop: occupancy unchanged. Pushing into an empty buffer does not pop that edge.
//  Load: mem_read=0 -> mem_read_data=0.
//   mem_read=1 -> youngest buffered entry with matching addr wins; else array[address].
//   A store issued in the same cycle is not visible to the load: the load returns the pre-store value.
//  Latency: load 0 cycles. Store visible to loads the cycle after its edge (forwarded).
//   Store reaches the array DRAIN_INTERVAL edges after reaching buffer head.
//  Reset mid-drain: all buffered stores lost; no partial array write.
//  Both mem_read and mem_write may be high. Address width is exact; no out-of-range case.
// CONFIGURATION
//  DMEM_STATS_EN defined: adds two output ports.
//   read_count  output 16  counts cycles with mem_read=1
//   write_count output 16  counts accepted pushes; dropped stores are excluded
//   Both saturate at 16'hFFFF and reset to 0.
//  Undefined: neither port nor its counter exists. All other behaviour is identical.
// TESTING
//  1 Reset, then read addr 0..15 -> mem_read_data=0. wbuf_empty=1, wbuf_full=0, wr_overflow=0.
//  2 Write 32'hDEADBEEF to addr 3, then read addr 3 next cycle -> 32'hDEADBEEF with wbuf_empty=0.
//    2 edges later wbuf_empty=1 and the read still returns 32'hDEADBEEF from the array.
//  3 Back-to-back writes addr 5 = 32'h11 then 32'h22, then read addr 5 -> 32'h22 (youngest forward).
//    After drain, array[5]=32'h22.
//  4 DRAIN_INTERVAL=8: 5 consecutive writes to addr 0..4 with values 1..5.
//    Result: wbuf_full=1 after 4th, 5th dropped, wr_overflow=1, read addr 4 -> 0 after full drain.
//  5 Write + read addr 7 same cycle, old value 32'hA: read returns 32'hA. Next cycle read returns new value.
//  6 Three entries buffered (DRAIN_INTERVAL=8), assert rst -> wbuf_empty=1 immediately.
//    Reads of those addresses return 0 after release.
//  DMEM_STATS_EN builds: cases 1-6 re-run. Case 4 -> write_count=4.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory responder with posted FIFO write buffer, store-to-load forwarding
// and rate-limited drain to the word array; define DMEM_STATS_EN to add read_count/write_count.
module data_memory_responder #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int WBUF_DEPTH     = 4,
  parameter int DRAIN_INTERVAL = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              wbuf_full,
  output logic              wbuf_empty,
  output logic              wr_overflow
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
`endif
);
  localparam int WORDS = 1 << ADDR_W;
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int OW = $clog2(WBUF_DEPTH + 1);
  localparam int CW = $clog2(DRAIN_INTERVAL + 1);
  localparam logic [PW-1:0] PLAST = PW'(WBUF_DEPTH - 1);
  localparam logic [OW-1:0] OFULL = OW'(WBUF_DEPTH);
  localparam logic [CW-1:0] DLAST = CW'(DRAIN_INTERVAL - 1);

  logic [DATA_W-1:0] arr_q [WORDS];
  logic [ADDR_W-1:0] ba_q [WBUF_DEPTH];
  logic [DATA_W-1:0] bd_q [WBUF_DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, idx;
  logic [OW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic              ovf_q, pop, push, hit;
  logic [DATA_W-1:0] fwd;

  assign wbuf_empty  = occ_q == '0;
  assign wbuf_full   = occ_q == OFULL;
  assign wr_overflow = ovf_q;
  // pop is decided on the pre-edge occupancy, so a push into an empty buffer never pops
  assign pop  = !wbuf_empty && drain_q == DLAST;
  assign push = mem_write && (!wbuf_full || pop);

  always_comb begin
    head_d  = pop ? ((head_q == PLAST) ? '0 : head_q + 1'b1) : head_q;
    tail_d  = push ? ((tail_q == PLAST) ? '0 : tail_q + 1'b1) : tail_q;
    occ_d   = occ_q + OW'(push) - OW'(pop);
    drain_d = (wbuf_empty || pop) ? '0 : drain_q + 1'b1;
  end

  // walk oldest to youngest so the youngest matching entry is the one left in fwd
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = PW'((int'(head_q) + i) % WBUF_DEPTH);
      if (i < int'(occ_q) && ba_q[idx] == address) begin
        hit = 1'b1;
        fwd = bd_q[idx];
      end
    end
  end

  assign mem_read_data = !mem_read ? '0 : hit ? fwd : arr_q[address];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) arr_q[i] <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        ba_q[i] <= '0;
        bd_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      drain_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop) arr_q[ba_q[head_q]] <= bd_q[head_q];
      if (push) begin
        ba_q[tail_q] <= address;
        bd_q[tail_q] <= mem_write_data;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      drain_q <= drain_d;
      if (mem_write && !push) ovf_q <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rc_q, wc_q;
  assign read_count  = rc_q;
  assign write_count = wc_q;
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rc_q <= '0;
      wc_q <= '0;
    end else begin
      rc_q <= (mem_read && rc_q != 16'hFFFF) ? rc_q + 16'd1 : rc_q;
      wc_q <= (push && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;
    end
  end
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized + directed stimulus against a queue-based memory model;
// expected responses go through a scoreboard queue checked by an independent monitor.
module tb_data_memory_responder;
  localparam int DEPTH = 4;
  localparam int DI    = 2;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        wbuf_full, wbuf_empty, wr_overflow;
`ifdef DMEM_STATS_EN
  logic [15:0] read_count, write_count;
`endif

  data_memory_responder #(
    .ADDR_W(4), .DATA_W(32), .WBUF_DEPTH(DEPTH), .DRAIN_INTERVAL(DI)
  ) dut (
    .clock(clock),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .address(address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .wbuf_full(wbuf_full),
    .wbuf_empty(wbuf_empty),
    .wr_overflow(wr_overflow)
`ifdef DMEM_STATS_EN
    ,
    .read_count(read_count),
    .write_count(write_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } st_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        e, f, o;
    logic [15:0] rc, wc;
  } exp_t;

  // reference model: pending stores in program order plus the backing word array
  st_t         pend[$];
  logic [31:0] mem[16];
  int          timer;
  logic        m_ovf;
  logic [15:0] m_rc, m_wc;
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] m_load(input logic [3:0] a);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].a == a) return pend[i].d;
    return mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    pend.delete();
    timer = 0;
    m_ovf = 1'b0;
    m_rc  = '0;
    m_wc  = '0;
  endtask

  task automatic m_edge(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    st_t p;
    if (pend.size() != 0) begin
      if (timer == DI - 1) begin
        mem[pend[0].a] = pend[0].d;
        void'(pend.pop_front());
        timer = 0;
      end else timer++;
    end
    if (w) begin
      if (pend.size() < DEPTH) begin
        p.a = a;
        p.d = d;
        pend.push_back(p);
        if (m_wc != 16'hFFFF) m_wc++;
      end else m_ovf = 1'b1;
    end
    if (r && m_rc != 16'hFFFF) m_rc++;
  endtask

  task automatic cyc(input logic r, input logic w, input logic rn, input logic [3:0] a,
                     input logic [31:0] d);
    exp_t e;
    @(posedge clock);
    #1;
    rst = rn;
    mem_read = r;
    mem_write = w;
    address = a;
    mem_write_data = d;
    if (!rn) m_reset();
    e.rd = r ? m_load(a) : 32'h0;
    e.e  = pend.size() == 0;
    e.f  = pend.size() == DEPTH;
    e.o  = m_ovf;
    e.rc = m_rc;
    e.wc = m_wc;
    exp_q.push_back(e);
    if (rn) m_edge(r, w, a, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", mem_read_data, e.rd);
        chk("wbuf_empty", 32'(wbuf_empty), 32'(e.e));
        chk("wbuf_full", 32'(wbuf_full), 32'(e.f));
        chk("wr_overflow", 32'(wr_overflow), 32'(e.o));
`ifdef DMEM_STATS_EN
        chk("read_count", 32'(read_count), 32'(e.rc));
        chk("write_count", 32'(write_count), 32'(e.wc));
`endif
      end
    end
  end

  initial begin : stim
    m_reset();
    cyc(1, 0, 0, 4'd0, 0);
    cyc(0, 0, 0, 4'd0, 0);
    // 1: every word reads zero after reset
    for (int a = 0; a < 16; a++) cyc(1, 0, 1, 4'(a), 0);
    // 2: single store, forwarded then drained
    cyc(0, 1, 1, 4'd3, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 4'd3, 0);
    // 3: youngest of two stores to the same word wins
    cyc(0, 1, 1, 4'd5, 32'h11);
    cyc(0, 1, 1, 4'd5, 32'h22);
    cyc(1, 0, 1, 4'd5, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 4'd0, 0);
    cyc(1, 0, 1, 4'd5, 0);
    // 5: same-cycle store is invisible to the load
    cyc(0, 1, 1, 4'd7, 32'hA);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 4'd0, 0);
    cyc(1, 1, 1, 4'd7, 32'hCAFE0007);
    cyc(1, 0, 1, 4'd7, 0);
    // 4: back-to-back stores fill the buffer and overflow
    for (int i = 0; i < 10; i++) cyc(i[0], 1, 1, 4'(i), 32'(i + 1));
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 4'(i), 0);
    // 6: reset with stores in flight
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'(8 + i), 32'h100 + 32'(i));
    cyc(1, 0, 0, 4'd8, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'(8 + i), 0);
    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] a;
      a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55), ($urandom_range(0, 199) != 0),
          a, $urandom);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'd0, 0);
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
